// File: rtl/dbg_cmd_ctrl.sv
// Debugger command sequencer: parses host bytes from the UART, gates the DUT
// clock enable (step / run / halt) and streams a probe snapshot back.
module dbg_cmd_ctrl #(
  parameter int unsigned PROBE_BYTES = 4,
  parameter logic [7:0]  ACK_BYTE    = 8'hA5,
  parameter logic [7:0]  NAK_BYTE    = 8'hEE
) (
  input  logic                     iCE_CLK,
  input  logic                     RST_N,
  input  logic [7:0]               RX_BYTE,
  input  logic                     RX_VALID,
  input  logic                     TX_BUSY,
  output logic [7:0]               TX_BYTE,
  output logic                     TX_START,
  input  logic [8*PROBE_BYTES-1:0] PROBE,
  output logic                     DUT_CE,
  output logic                     RUNNING,
  output logic                     ERR
);

  localparam int unsigned IW = (PROBE_BYTES > 1) ? $clog2(PROBE_BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARG_HI, S_ARG_LO, S_STEP, S_RUN, S_SEND, S_TX_GUARD, S_TX_WAIT
  } state_t;

  state_t                   state_q;
  logic [15:0]              cnt_q;
  logic [8*PROBE_BYTES-1:0] snap_q;
  logic [IW-1:0]            idx_q;
  logic                     rd_q;
  logic [7:0]               reply_q;
  logic [7:0]               tx_byte_q;
  logic                     tx_start_q;
  logic                     dut_ce_q;
  logic                     running_q;
  logic                     err_q;
  logic [7:0]               rd_byte;

  assign TX_BYTE  = tx_byte_q;
  assign TX_START = tx_start_q;
  assign DUT_CE   = dut_ce_q;
  assign RUNNING  = running_q;
  assign ERR      = err_q;

  always_comb begin
    rd_byte = '0;
    for (int unsigned i = 0; i < PROBE_BYTES; i++) begin
      if (idx_q == IW'(i)) rd_byte = snap_q[i*8 +: 8];
    end
  end

  always_ff @(posedge iCE_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      snap_q     <= '0;
      idx_q      <= '0;
      rd_q       <= 1'b0;
      reply_q    <= '0;
      tx_byte_q  <= '0;
      tx_start_q <= 1'b0;
      dut_ce_q   <= 1'b0;
      running_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (RX_VALID) begin
            case (RX_BYTE)
              8'h01: state_q <= S_ARG_HI;
              8'h02: begin
                state_q   <= S_RUN;
                dut_ce_q  <= 1'b1;
                running_q <= 1'b1;
              end
              8'h03: begin
                reply_q <= ACK_BYTE;
                rd_q    <= 1'b0;
                state_q <= S_SEND;
              end
              8'h04: begin
                snap_q  <= PROBE;
                idx_q   <= '0;
                rd_q    <= 1'b1;
                state_q <= S_SEND;
              end
              default: begin
                err_q   <= 1'b1;
                reply_q <= NAK_BYTE;
                rd_q    <= 1'b0;
                state_q <= S_SEND;
              end
            endcase
          end
        end
        S_ARG_HI: begin
          if (RX_VALID) begin
            cnt_q[15:8] <= RX_BYTE;
            state_q     <= S_ARG_LO;
          end
        end
        S_ARG_LO: begin
          if (RX_VALID) begin
            cnt_q[7:0] <= RX_BYTE;
            reply_q    <= ACK_BYTE;
            rd_q       <= 1'b0;
            if ({cnt_q[15:8], RX_BYTE} == 16'd0) begin
              state_q <= S_SEND;
            end else begin
              state_q  <= S_STEP;
              dut_ce_q <= 1'b1;
            end
          end
        end
        S_STEP: begin
          if (RX_VALID) err_q <= 1'b1;
          // The cycle holding count 1 is the last enabled one.
          if (cnt_q == 16'd1) begin
            cnt_q    <= '0;
            dut_ce_q <= 1'b0;
            state_q  <= S_SEND;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_RUN: begin
          if (RX_VALID) begin
            if (RX_BYTE == 8'h03) begin
              dut_ce_q  <= 1'b0;
              running_q <= 1'b0;
              reply_q   <= ACK_BYTE;
              rd_q      <= 1'b0;
              state_q   <= S_SEND;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (RX_VALID) err_q <= 1'b1;
          if (!TX_BUSY) begin
            tx_byte_q  <= rd_q ? rd_byte : reply_q;
            tx_start_q <= 1'b1;
            state_q    <= S_TX_GUARD;
          end
        end
        S_TX_GUARD: begin
          if (RX_VALID) err_q <= 1'b1;
          state_q <= S_TX_WAIT;
        end
        S_TX_WAIT: begin
          if (RX_VALID) err_q <= 1'b1;
          if (!TX_BUSY) begin
            if (rd_q && (idx_q != IW'(PROBE_BYTES - 1))) begin
              idx_q   <= idx_q + 1'b1;
              state_q <= S_SEND;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dbg_cmd_ctrl.md
Name: dbg_cmd_ctrl

Overview:
Command sequencer between the UART byte interface and the design under test (DUT) in the FPGA hardware debugger.
- Parses host command bytes delivered by the UART receiver.
- Gates the DUT clock enable: single-step by count, free-run, or halt.
- Snapshots a probe bus and streams it back byte-by-byte through the UART transmitter, one transmission at a time.

Parameters:
PROBE_BYTES, 4, number of 8-bit probe bytes returned by READ (1..16)
ACK_BYTE, 8'hA5, reply sent on completion of STEP/HALT
NAK_BYTE, 8'hEE, reply sent on an unknown opcode

Ports:
iCE_CLK  in  1  system clock (12 MHz)
RST_N  in  1  asynchronous active-low reset
RX_BYTE  in  8  byte from UART receiver
RX_VALID  in  1  one-cycle pulse; RX_BYTE valid (UART received)
TX_BUSY  in  1  UART is_transmitting
TX_BYTE  out  8  byte to UART transmitter
TX_START  out  1  one-cycle transmit request
PROBE  in  8*PROBE_BYTES  DUT observation bus
DUT_CE  out  1  DUT clock enable
RUNNING  out  1  high in RUN state
ERR  out  1  sticky protocol error

Behaviour:
- Reset (RST_N low, async):
  - State goes to IDLE.
  - DUT_CE=0, TX_START=0, TX_BYTE=0, RUNNING=0, ERR=0.
  - Step counter, probe snapshot and byte index are all cleared.
  - Reset mid-step or mid-send aborts immediately; DUT_CE drops with RST_N, not at the next edge.
- All outputs are registered.
- Opcodes (accepted in IDLE only):
  - 0x01 STEP, followed by count MSB then count LSB (16-bit unsigned n).
  - 0x02 RUN.
  - 0x03 HALT.
  - 0x04 READ.
  - Any other byte: ERR set, NAK_BYTE queued.
- States: IDLE, ARG_HI, ARG_LO, STEP, RUN, SEND, TX_GUARD, TX_WAIT.
- IDLE:
  - RX_VALID with 0x01 -> ARG_HI.
  - 0x02 -> RUN; DUT_CE=1 and RUNNING=1 from the next cycle. No reply is sent.
  - 0x03 -> SEND ACK_BYTE (DUT already halted).
  - 0x04 -> PROBE captured on the same edge; go to SEND with index 0.
- ARG_HI / ARG_LO:
  - Each RX_VALID loads the count byte, high byte first.
  - After the LSB: n=0 goes directly to SEND ACK; otherwise go to STEP.
- STEP:
  - DUT_CE=1 for exactly n consecutive cycles, starting the cycle after the LSB edge.
  - Counter decrements each cycle. At 1, the next cycle has DUT_CE=0 and the state becomes SEND ACK.
  - Counter is 16 bits; n=16'hFFFF gives 65535 cycles with no wrap.
- RUN:
  - DUT_CE held at 1.
  - RX_VALID with 0x03 -> DUT_CE=0 and RUNNING=0 next cycle, then SEND ACK.
  - Any other byte is dropped and ERR is set; RUN continues.
- SEND:
  - Waits for TX_BUSY=0, then drives TX_BYTE and pulses TX_START for one cycle -> TX_GUARD.
  - READ byte order: snapshot[7:0] first, ascending, PROBE_BYTES bytes.
  - ACK and NAK replies are single-byte sends.
- TX_GUARD: one cycle; TX_BUSY is ignored so the UART has time to raise is_transmitting -> TX_WAIT.
- TX_WAIT:
  - Waits for TX_BUSY=0.
  - If more READ bytes remain, increment index and go to SEND; else go to IDLE.
- RX_VALID in STEP, SEND, TX_GUARD, TX_WAIT or ARG states:
  - ARG states consume the byte as an argument.
  - In every other listed state the byte is dropped and ERR is set.
  - RX_VALID on the same cycle a step finishes counts as a drop.
- ERR clears only on reset.
- The probe snapshot is never updated during a send, even if PROBE changes.
- Throughput: at most one TX_START in flight. TX_START is never asserted while TX_BUSY=1.

Test Plan:
- STEP, count 0x0005: send 0x01,0x00,0x05 -> DUT_CE high exactly 5 cycles starting the cycle after the third RX_VALID, then one TX_START with TX_BYTE=0xA5; ERR=0.
- STEP with n=0 (0x01,0x00,0x00) -> no DUT_CE cycle; single 0xA5 reply.
- READ, PROBE_BYTES=4, PROBE=32'hDEADBEEF at the command cycle, PROBE changed afterward -> four TX_STARTs with bytes EF,BE,AD,DE, each only after TX_BUSY falls; then IDLE.
- RUN, then three cycles of traffic, then 0x55, then HALT:
  - RUNNING=1 and DUT_CE=1 until 0x03 is received.
  - 0x55 sets ERR and RUN continues.
  - 0x03 drops DUT_CE the next cycle and 0xA5 is sent.
- Unknown opcode 0x7F -> TX_BYTE=0xEE, ERR=1 and held; a subsequent STEP still works normally.
- Reset mid-step: assert RST_N low during STEP n=1000 -> DUT_CE=0 asynchronously, no ACK sent; after release, IDLE and a new READ works.
